// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
// Holds the FSM state type, FIPS-197 reference vectors and the core latency helper.
package aes_sched_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} sched_state_t;

  localparam logic [BLK_W-1:0] FIPS_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BLK_W-1:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BLK_W-1:0] FIPS_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // RUN cycles the core needs before done: 10/12/14 encrypt, doubled for decrypt.
  function automatic int unsigned core_cycles(int unsigned k, logic dir);
    int unsigned n;
    n = 10 + (k - 128) / 32;
    return dir ? 2 * n : n;
  endfunction

endpackage

// File: rtl/aes_sched_if.sv
// Requester-side request/response bus of the AES scheduler.
interface aes_sched_if
  import aes_sched_pkg::*;
#(
  parameter int unsigned K    = 128,
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*K-1:0]     req_key;
  logic [NREQ*BLK_W-1:0] req_msg;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [BLK_W-1:0]      rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_key, req_msg, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_msg, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/aes_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NREQ);
      if (en && !any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/aes_sched.sv
// Shares one AES core among NREQ requesters: grant, load, run with timeout,
// then hold the result for the owning requester until it is accepted.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned K       = 128,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LOADCYC = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  aes_sched_if.slave       bus,
  output logic             core_ce,
  output logic             core_dir,
  output logic [K-1:0]     core_key,
  output logic [BLK_W-1:0] core_msg,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_translated
);
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LC_W  = (LOADCYC > 1) ? $clog2(LOADCYC) : 1;
  localparam int unsigned RC_W  = $clog2(TIMEOUT + 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [LC_W-1:0]  load_cnt_q, load_cnt_d;
  logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
  logic             core_ce_q, core_ce_d;
  logic             core_dir_q, core_dir_d;
  logic [K-1:0]     core_key_q, core_key_d;
  logic [BLK_W-1:0] core_msg_q, core_msg_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  gnt_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .en    (state_q == IDLE),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Next-state and register updates; core_done is only looked at in RUN.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    load_cnt_d  = load_cnt_q;
    run_cnt_d   = run_cnt_q;
    core_ce_d   = core_ce_q;
    core_dir_d  = core_dir_q;
    core_key_d  = core_key_q;
    core_msg_d  = core_msg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          core_key_d = bus.req_key[32'(gnt_idx) * K +: K];
          core_msg_d = bus.req_msg[32'(gnt_idx) * BLK_W +: BLK_W];
          core_dir_d = bus.req_dir[gnt_idx];
          owner_d    = gnt_idx;
          ptr_d      = IDX_W'((32'(gnt_idx) + 32'd1) % NREQ);
          load_cnt_d = '0;
          run_cnt_d  = '0;
          core_ce_d  = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        load_cnt_d = load_cnt_q + LC_W'(1);
        if (load_cnt_q == LC_W'(LOADCYC - 1)) begin
          core_ce_d = 1'b0;
          run_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RC_W'(1);
        if (core_done) begin
          rsp_data_d           = core_translated;
          rsp_err_d            = 1'b0;
          rsp_valid_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = HOLD;
        end else if (run_cnt_d == RC_W'(TIMEOUT)) begin
          rsp_data_d           = '0;
          rsp_err_d            = 1'b1;
          rsp_valid_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = HOLD;
        end
      end
      HOLD: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      load_cnt_q  <= '0;
      run_cnt_q   <= '0;
      core_ce_q   <= 1'b0;
      core_dir_q  <= 1'b0;
      core_key_q  <= '0;
      core_msg_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      load_cnt_q  <= load_cnt_d;
      run_cnt_q   <= run_cnt_d;
      core_ce_q   <= core_ce_d;
      core_dir_q  <= core_dir_d;
      core_key_q  <= core_key_d;
      core_msg_q  <= core_msg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign core_ce       = core_ce_q;
  assign core_dir      = core_dir_q;
  assign core_key      = core_key_q;
  assign core_msg      = core_msg_q;
endmodule

// File: tb/tb_aes_sched.sv
// Scoreboard bench for aes_sched with a behavioural AES core stand-in that
// answers the FIPS-197 vectors after the documented number of RUN cycles.
module tb_aes_sched;
  import aes_sched_pkg::*;

  localparam int unsigned K       = 128;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned LOADCYC = 2;
  localparam int unsigned TIMEOUT = 63;
  localparam int          LAT_ENC = 1 + LOADCYC + 10 + 1;
  localparam int          LAT_DEC = 1 + LOADCYC + 20 + 1;
  localparam int          LAT_TO  = 1 + LOADCYC + TIMEOUT;
  localparam int          STALL_RSP = 4;
  localparam int          STALL_CYC = 5;

  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
    int           lat;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             core_ce;
  logic             core_dir;
  logic [K-1:0]     core_key;
  logic [127:0]     core_msg;
  logic             core_done;
  logic [127:0]     core_translated;

  aes_sched_if #(.K(K), .NREQ(NREQ)) bus ();

  aes_sched #(.K(K), .NREQ(NREQ), .LOADCYC(LOADCYC), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .core_ce         (core_ce),
    .core_dir        (core_dir),
    .core_key        (core_key),
    .core_msg        (core_msg),
    .core_done       (core_done),
    .core_translated (core_translated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   gnt_q[$];
  int   cyc = 0;

  // Core stand-in: no reset, done stays high until the next load.
  logic         tie_done0  = 1'b0;
  logic         force_done = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b1;
  int           m_cnt = 0;
  int           m_target = 0;
  logic [127:0] m_res = 128'hdeadbeef_0badf00d_12345678_9abcdef0;

  function automatic logic [127:0] xlate(logic [K-1:0] key, logic [127:0] msg, logic dir);
    if (key == FIPS_KEY128 && !dir && msg == FIPS_PT) return FIPS_CT128;
    if (key == FIPS_KEY128 && dir && msg == FIPS_CT128) return FIPS_PT;
    return msg ^ key;
  endfunction

  always @(posedge clk) begin
    if (core_ce) begin
      m_busy   <= 1'b1;
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_target <= int'(core_cycles(K, core_dir));
      m_res    <= xlate(core_key, core_msg, core_dir);
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_target) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
    end
  end

  assign core_done       = (m_done & ~tie_done0) | force_done;
  assign core_translated = m_res;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
    chk({tag, "_rsp_err"},   128'(bus.rsp_err), 128'(0));
    chk({tag, "_rsp_data"},  bus.rsp_data, 128'(0));
    chk({tag, "_core_ce"},   128'(core_ce), 128'(0));
    chk({tag, "_core_dir"},  128'(core_dir), 128'(0));
    chk({tag, "_core_key"},  128'(core_key), 128'(0));
    chk({tag, "_core_msg"},  core_msg, 128'(0));
  endtask

  task automatic present(input int r, input logic [127:0] key, input logic [127:0] msg,
                         input logic dir, input logic push, input logic [127:0] exp_data,
                         input logic exp_err, input int lat);
    exp_t e;
    bus.req_key[r*K +: K]     = key;
    bus.req_msg[r*128 +: 128] = msg;
    bus.req_dir[r]            = dir;
    bus.req_valid[r]          = 1'b1;
    if (push) begin
      e = '{idx: r, data: exp_data, err: exp_err, lat: lat};
      exp_q.push_back(e);
    end
  endtask

  // Returns #1 after the grant edge (first LOAD cycle); operands are then scrambled.
  task automatic wait_grant(input int r);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready[r]) break;
      n++;
      if (n > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL grant_timeout req%0d: got no grant expected grant", r);
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid[r]          = 1'b0;
    bus.req_key[r*K +: K]     = ~bus.req_key[r*K +: K];
    bus.req_msg[r*128 +: 128] = ~bus.req_msg[r*128 +: 128];
    bus.req_dir[r]            = ~bus.req_dir[r];
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || bus.rsp_valid != '0) begin
      @(posedge clk);
      n++;
      if (n > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks each presented response against the scoreboard and drives rsp_ready.
  initial begin : monitor
    logic            active;
    logic            gave_ready;
    int              stall_left;
    int              rsp_num;
    int              lat;
    logic [127:0]    last_data;
    logic            last_err;
    logic [NREQ-1:0] last_v;
    logic [NREQ-1:0] ev;
    exp_t            e;
    active = 1'b0; gave_ready = 1'b0; stall_left = 0; rsp_num = 0;
    last_data = '0; last_err = 1'b0; last_v = '0;
    bus.rsp_ready = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        gnt_q.delete();
        active = 1'b0;
        gave_ready = 1'b0;
        bus.rsp_ready = '0;
      end else begin
        if (bus.req_ready != '0) gnt_q.push_back(cyc);
        if (gave_ready) begin
          chk("rsp_valid_drop", 128'(bus.rsp_valid), 128'(0));
          gave_ready = 1'b0;
          active = 1'b0;
          bus.rsp_ready = '0;
        end else if (bus.rsp_valid != '0) begin
          if (!active) begin
            active = 1'b1;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_rsp: got rsp_valid %b expected none", bus.rsp_valid);
            end else begin
              e = exp_q.pop_front();
              ev = '0;
              ev[e.idx] = 1'b1;
              lat = (gnt_q.size() != 0) ? cyc - gnt_q.pop_front() : -1;
              chk("rsp_owner", 128'(bus.rsp_valid), 128'(ev));
              chk("rsp_data", bus.rsp_data, e.data);
              chk("rsp_err", 128'(bus.rsp_err), 128'(e.err));
              chk("latency", 128'(lat), 128'(e.lat));
            end
            stall_left = (rsp_num == STALL_RSP) ? STALL_CYC : 0;
            rsp_num++;
          end else begin
            chk("hold_valid_stable", 128'(bus.rsp_valid), 128'(last_v));
            chk("hold_data_stable", bus.rsp_data, last_data);
            chk("hold_err_stable", 128'(bus.rsp_err), 128'(last_err));
          end
          chk("hold_no_grant", 128'(bus.req_ready), 128'(0));
          chk("hold_no_ce", 128'(core_ce), 128'(0));
          last_v = bus.rsp_valid;
          last_data = bus.rsp_data;
          last_err = bus.rsp_err;
          if (stall_left > 0) begin
            stall_left--;
            bus.rsp_ready = '0;
          end else begin
            bus.rsp_ready = bus.rsp_valid;
            gave_ready = 1'b1;
          end
        end else begin
          bus.rsp_ready = '0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_key   = '0;
    bus.req_msg   = '0;
    bus.req_dir   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // Single encrypt then single decrypt on the other requester.
    present(0, FIPS_KEY128, FIPS_PT, 1'b0, 1'b1, FIPS_CT128, 1'b0, LAT_ENC);
    wait_grant(0);
    drain();
    present(1, FIPS_KEY128, FIPS_CT128, 1'b1, 1'b1, FIPS_PT, 1'b0, LAT_DEC);
    wait_grant(1);
    drain();

    // Two simultaneous pairs with ptr back at 0; the second pair has a stalled response.
    for (int p = 0; p < 2; p++) begin
      present(0, FIPS_KEY128, FIPS_PT, 1'b0, 1'b1, FIPS_CT128, 1'b0, LAT_ENC);
      present(1, FIPS_KEY128, FIPS_CT128, 1'b1, 1'b1, FIPS_PT, 1'b0, LAT_DEC);
      wait_grant(0);
      wait_grant(1);
      drain();
    end

    // Core never finishes: timeout response.
    tie_done0 = 1'b1;
    present(0, FIPS_KEY128, FIPS_PT, 1'b0, 1'b1, 128'(0), 1'b1, LAT_TO);
    wait_grant(0);
    drain();
    tie_done0 = 1'b0;

    // Spurious done during LOAD must not end the operation early.
    present(1, FIPS_KEY128, FIPS_PT, 1'b0, 1'b1, FIPS_CT128, 1'b0, LAT_ENC);
    wait_grant(1);
    force_done = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 force_done = 1'b0;
    drain();

    // Reset in RUN cycle 4 discards the operation.
    present(1, FIPS_KEY128, FIPS_PT, 1'b0, 1'b0, '0, 1'b0, 0);
    wait_grant(1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // After reset ptr is 0 again: req0 wins over req1, and results are correct.
    present(0, FIPS_KEY128, FIPS_PT, 1'b0, 1'b1, FIPS_CT128, 1'b0, LAT_ENC);
    present(1, FIPS_KEY128, FIPS_CT128, 1'b1, 1'b1, FIPS_PT, 1'b0, LAT_DEC);
    wait_grant(0);
    wait_grant(1);
    drain();

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
